md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline; owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and drives busy to the stall unit.
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Exception/interrupt request from CP0 (req) squashes any HI/LO-affecting op in E that cycle.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU.
- DIV_CYCLES, 10, busy duration for DIV/DIVU.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op  input  4  operation code from md_pkg: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- start  input  1  E-stage instruction is a MULT/MULTU/DIV/DIVU this cycle.
- req  input  1  exception/interrupt taken this cycle; suppresses start and MTHI/MTLO.
- rs_val  input  32  forwarded rs operand (dividend/multiplicand; MTHI/MTLO source).
- rt_val  input  32  forwarded rt operand (divisor/multiplier).
- busy  output  1  operation in flight, to stall unit.
- hl_out  output  32  HI when op==MFHI, LO otherwise; combinational from registers.

Behaviour:
- Reset (async, reset_n low): state=IDLE, counter=0, HI=0, LO=0, temp result regs=0; busy=0 immediately.
- States: IDLE, BUSY.
- IDLE with start & !req & op in {MULT, MULTU, DIV, DIVU}:
  - latch computed {hi_tmp, lo_tmp} at the edge;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY: counter decrements each edge.
  - At the edge where counter==1: HI<=hi_tmp, LO<=lo_tmp, state<=IDLE.
  - busy = (state==BUSY).
- Timing, start sampled at edge ending cycle 0: busy high for cycles 1..N; HI/LO new value visible cycle N+1; busy low cycle N+1.
- start in same cycle as req: ignored; no state change.
- start while BUSY: ignored. The stall unit guarantees this does not happen; the bench asserts it.
- MTHI/MTLO in IDLE with !req: HI or LO <= rs_val at edge. Ignored while BUSY.
- MFHI/MFLO: pure combinational read; no side effect.
- req during BUSY does not cancel the in-flight op; it still commits. The op's instruction has already left E.
- Arithmetic:
  - MULT: 64-bit signed product; HI=[63:32], LO=[31:0].
  - MULTU: same, unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with sign of dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV/DIVU): full busy period runs; HI and LO are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset mid-operation: op is discarded; busy, HI and LO go to 0 immediately.

Decomposition:
- md_pkg holds:
  - op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8;
  - state encodings;
  - default cycle constants.
- Single module; no sub-module. The arithmetic is combinational, latched into temp regs at start.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFHI/MFLO return these.
- MULTU rs=0xFFFFFFFF, rt=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=7, rt=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- start=1 op=MULT with req=1; then MTLO rs=0x55 with req=1 -> busy stays 0; LO unchanged.
- DIV in flight, reset_n pulsed low at busy cycle 4 -> busy=0 and HI=LO=0 asynchronously; no commit afterwards.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared types and constants for the multiply/divide unit:
//                operation codes, FSM state encoding and default latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

  // Operation codes presented by the E stage
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  // Controller states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Default busy durations
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
//                The result is computed combinationally at issue, parked in
//                temporary registers and committed to HI/LO when the fixed
//                latency expires, so that software sees the MIPS timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hl_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_tmp_q, hi_tmp_d;
  logic [31:0]        lo_tmp_q, lo_tmp_d;
  logic               skip_q, skip_d;

  logic               is_mul, is_div, is_signed_div;
  logic [63:0]        prod_s, prod_u;
  logic               rs_neg, rt_neg;
  logic [31:0]        mag_a, mag_b, mag_b_safe, quo_mag, rem_mag;
  logic [31:0]        quo, rem;

  // Operation classification and the combinational arithmetic datapath
  always_comb begin
    is_mul        = (op == OP_MULT) || (op == OP_MULTU);
    is_div        = (op == OP_DIV)  || (op == OP_DIVU);
    is_signed_div = (op == OP_DIV);

    prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide is done on magnitudes; this also yields the
    // 0x80000000 / -1 case (quotient 0x80000000, remainder 0) naturally.
    rs_neg     = is_signed_div & rs_val[31];
    rt_neg     = is_signed_div & rt_val[31];
    mag_a      = rs_neg ? (32'd0 - rs_val) : rs_val;
    mag_b      = rt_neg ? (32'd0 - rt_val) : rt_val;
    // A zero divisor never commits; substitute 1 to keep the datapath defined
    mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo_mag    = mag_a / mag_b_safe;
    rem_mag    = mag_a % mag_b_safe;
    quo        = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem        = rs_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  // Next-state, counter and HI/LO update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    skip_d   = skip_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !req && (is_mul || is_div)) begin
          state_d = ST_BUSY;
          if (is_mul) begin
            cnt_d    = CNT_W'(MULT_CYCLES);
            skip_d   = 1'b0;
            hi_tmp_d = (op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
            lo_tmp_d = (op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
          end else begin
            cnt_d    = CNT_W'(DIV_CYCLES);
            skip_d   = (rt_val == 32'd0);
            hi_tmp_d = rem;
            lo_tmp_d = quo;
          end
        end else if (!req && (op == OP_MTHI)) begin
          hi_d = rs_val;
        end else if (!req && (op == OP_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_BUSY: begin
        // req here cannot cancel: the owning instruction already left E
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!skip_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      skip_q   <= skip_d;
    end
  end

  // Stall request and combinational HI/LO read port
  always_comb begin
    busy   = (state_q == ST_BUSY);
    hl_out = (op == OP_MFHI) ? hi_q : lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Scoreboard bench for md_unit. Stimulus queues the expected
//                LO value and busy length of each multiply/divide; a monitor
//                checks them when busy falls. HI/LO reads are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
  import md_pkg::*;

  typedef struct {
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  op_r;
  logic        start;
  logic        req;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hl_out;

  int   checks;
  int   errors;
  exp_t sb_q[$];

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .op     (op_r),
    .start  (start),
    .req    (req),
    .rs_val (rs),
    .rt_val (rt),
    .busy   (busy),
    .hl_out (hl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: on each busy falling edge pop one expectation and compare
  bit prev_busy = 1'b0;
  int bcnt      = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
      bcnt      = 0;
    end else begin
      if (busy && start) begin
        checks++;
        errors++;
        $display("FAIL start_while_busy actual=1 required=0");
      end
      if (busy) begin
        bcnt++;
      end else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_commit actual=commit required=none");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_lo", hl_out, e.lo);
          chk("sb_busy_len", 32'(bcnt), 32'(e.cycles));
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  // Issue one mul/div op and wait (bounded) for busy to drop.
  // With disturb set, req and an MTHI are driven mid-flight.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_lo, input int n, input bit disturb);
    exp_t e;
    bit   done;
    @(posedge clk); #1;
    op_r = o; start = 1'b1; rs = a; rt = b;
    e.lo = exp_lo; e.cycles = n;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op_r = OP_NONE; rs = '0; rt = '0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (disturb && i == 2) begin req = 1'b1; op_r = OP_MTHI; rs = 32'hDEADBEEF; end
      if (disturb && i == 3) begin req = 1'b0; op_r = OP_NONE; rs = '0; end
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic read_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    @(posedge clk); #1;
    op_r = OP_MFHI; #1;
    chk({name, "_mfhi"}, hl_out, eh);
    op_r = OP_MFLO; #1;
    chk({name, "_mflo"}, hl_out, el);
    op_r = OP_NONE;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    op_r = o; rs = v;
    @(posedge clk); #1;
    op_r = OP_NONE; rs = '0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; op_r = OP_NONE; start = 1'b0; req = 1'b0; rs = '0; rt = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lo", hl_out, 32'd0);
    op_r = OP_MFHI; #1;
    chk("rst_hi", hl_out, 32'd0);
    op_r = OP_NONE;
    @(negedge clk) reset_n = 1'b1;

    // -3 * 5 = -15
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 5, 1'b0);
    read_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

    // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 5, 1'b0);
    read_hl("multu", 32'h00000001, 32'hFFFFFFFE);

    // -7 / 2 = -3 rem -1
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 10, 1'b0);
    read_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    // Overflow case
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 10, 1'b0);
    read_hl("div_ovf", 32'h00000000, 32'h80000000);

    // Preset HI/LO, then divide by zero leaves them alone
    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    read_hl("mt", 32'h11, 32'h22);
    issue(OP_DIVU, 32'd7, 32'd0, 32'h22, 10, 1'b0);
    read_hl("divu_zero", 32'h11, 32'h22);

    // start and MTLO while req is high are both suppressed
    @(posedge clk); #1;
    op_r = OP_MULT; start = 1'b1; req = 1'b1; rs = 32'd3; rt = 32'd3;
    @(posedge clk); #1;
    chk("req_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; op_r = OP_MTLO; rs = 32'h55;
    @(posedge clk); #1;
    op_r = OP_NONE; req = 1'b0; rs = '0; rt = '0;
    chk("req_mtlo_busy", {31'd0, busy}, 32'd0);
    read_hl("req", 32'h11, 32'h22);

    // req and MTHI during BUSY neither cancel nor corrupt: 100/7 = 14 rem 2
    issue(OP_DIVU, 32'd100, 32'd7, 32'h0000000E, 10, 1'b1);
    read_hl("divu_disturb", 32'h00000002, 32'h0000000E);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    op_r = OP_DIV; start = 1'b1; rs = 32'd100; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op_r = OP_NONE; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0; #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_lo", hl_out, 32'd0);
    op_r = OP_MFHI; #1;
    chk("async_rst_hi", hl_out, 32'd0);
    op_r = OP_NONE;
    @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    read_hl("post_rst", 32'd0, 32'd0);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
